pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle stage controller that owns the program counter for the 5-cycle LEGv8 datapath. Steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, emits one-hot stage enables, resolves branches in EXECUTE, and commits exactly one PC update per instruction at WRITEBACK exit. It replaces free-running "sync every 5th cycle" PC logic with an explicit, stallable sequencer.

## Interface
- ADDR_WIDTH, 32, PC and offset width
- RESET_PC, 0, PC value after reset; bits [1:0] must be 0
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold current stage; no state, PC or counter change
- branchFlag  in  1  conditional branch decoded; sampled in EXECUTE
- unconditionalBranchFlag  in  1  unconditional branch; sampled in EXECUTE
- zeroFlag  in  1  ALU zero; sampled in EXECUTE
- pcOffsetFilled  in  ADDR_WIDTH  sign-extended word offset; sampled in EXECUTE
- PC  out  ADDR_WIDTH  current instruction address (registered)
- stage  out  3  encoded stage, FETCH=0 … WRITEBACK=4
- fetchEnable, decodeEnable, executeEnable, memoryEnable, writebackEnable  out  1 each  one-hot decode of stage
- pcWrite  out  1  one-cycle pulse, high in the cycle PC takes its new value
- branchTaken  out  1  registered branch decision of current instruction
- retiredCount  out  32  instructions completed

## Operation
- FSM: FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK→FETCH, one step per clock when stall=0; stall=1 holds state.
- Encodings 5–7 unreachable; if entered, next state FETCH, PC unchanged.
- EXECUTE exit (stall=0): branchTaken <= (zeroFlag & branchFlag) | unconditionalBranchFlag; nextPc <= taken ? PC + (pcOffsetFilled << 2) : PC + 4. Inputs only sampled on that exit edge; values during stalled EXECUTE cycles are ignored.
- Arithmetic modulo 2^ADDR_WIDTH: 0xFFFFFFFC + 4 = 0x00000000; negative offsets wrap by two's complement. PC[1:0] remains 0.
- WRITEBACK exit (stall=0): PC <= nextPc, retiredCount += 1 (wraps 0xFFFFFFFF→0), branchTaken <= 0 on the same edge.
- Stall in WRITEBACK: PC unchanged until the exit edge; pcWrite not asserted while stalled.
- Reset (any time, mid-instruction included): stage=FETCH, PC=RESET_PC, nextPc=RESET_PC, branchTaken=0, retiredCount=0, pcWrite=0. Enables follow: fetchEnable=1, others 0. In-flight instruction is discarded, not retired.

## Timing
- Unstalled: 5 cycles per instruction; new PC visible in the first FETCH cycle of the next instruction.
- pcWrite is registered: high for exactly the one cycle following the WRITEBACK exit edge (coincides with first FETCH cycle), for both taken and not-taken.
- Stage enables combinational from the stage register only; no input-to-output combinational path.
- Each stall cycle adds exactly one cycle of latency to the stage it occurs in.
- branchTaken valid from MEMORY through WRITEBACK; 0 in FETCH, DECODE, EXECUTE.

## Structure
- Shared package pc_seq_pkg: stage enum (FETCH..WRITEBACK, 3-bit), STAGE_COUNT=5, PC_STEP=4, OFFSET_SHIFT=2.
- One sub-module: pc_target_unit (combinational): PC, offset, taken → next address. Everything else in pc_sequencer.

## Test plan
- Reset release, stall=0, no branches, RESET_PC=0: PC = 0,4,8 at cycles 5,10,15; pcWrite pulses every 5th cycle; retiredCount=3 after 15 cycles.
- Conditional taken: PC=0x100, branchFlag=1, zeroFlag=1, offset=0x10 in EXECUTE → PC=0x140, branchTaken=1 in MEMORY/WRITEBACK; zeroFlag=0 → PC=0x104.
- Unconditional backward: PC=0x40, unconditionalBranchFlag=1, offset=0xFFFFFFFC → PC=0x30; PC=0xFFFFFFFC not-taken → PC=0x0.
- Stall 3 cycles in EXECUTE, flags toggling during stall, taken only on exit cycle → taken decision used; instruction takes 8 cycles; single pcWrite pulse.
- Stall 2 cycles in WRITEBACK → PC and retiredCount unchanged until exit edge; pcWrite one cycle only.
- Assert reset in MEMORY with pending taken branch (target 0x200) → PC=RESET_PC, stage=FETCH, branchTaken=0, retiredCount unchanged from pre-reset 0-clear (=0), no pcWrite.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the multi-cycle PC sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } stage_e;

  localparam int STAGE_COUNT  = 5;
  localparam int PC_STEP      = 4;
  localparam int OFFSET_SHIFT = 2;

endpackage

// File: rtl/pc_target_unit.sv
// Next-address calculation: sequential step or word-offset branch target.
// All arithmetic wraps modulo 2^ADDR_WIDTH.
module pc_target_unit
  import pc_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic                  taken,
  output logic [ADDR_WIDTH-1:0] target
);

  logic [ADDR_WIDTH-1:0] step_target;
  logic [ADDR_WIDTH-1:0] branch_target;

  // Offset is in words, so scale to bytes before adding.
  assign step_target   = pc + ADDR_WIDTH'(PC_STEP);
  assign branch_target = pc + (offset << OFFSET_SHIFT);
  assign target        = taken ? branch_target : step_target;

endmodule

// File: rtl/pc_sequencer.sv
// Stallable five-stage controller that owns the PC: resolves the branch on
// EXECUTE exit and commits exactly one PC update on WRITEBACK exit.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branchFlag,
  input  logic                  unconditionalBranchFlag,
  input  logic                  zeroFlag,
  input  logic [ADDR_WIDTH-1:0] pcOffsetFilled,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [2:0]            stage,
  output logic                  fetchEnable,
  output logic                  decodeEnable,
  output logic                  executeEnable,
  output logic                  memoryEnable,
  output logic                  writebackEnable,
  output logic                  pcWrite,
  output logic                  branchTaken,
  output logic [31:0]           retiredCount
);

  stage_e                  stage_q, stage_d;
  logic                    exec_exit, wb_exit, taken_now;
  logic [ADDR_WIDTH-1:0]   pc_q, next_pc_q, target;
  logic                    branch_taken_q, pc_write_q;
  logic [31:0]             retired_q;
  logic [STAGE_COUNT-1:0]  onehot;

  // Stage register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stage_q <= FETCH;
    else       stage_q <= stage_d;
  end

  // Next stage and exit strobes; stall freezes everything, stray encodings recover to FETCH.
  always_comb begin
    stage_d   = stage_q;
    exec_exit = 1'b0;
    wb_exit   = 1'b0;
    if (!stall) begin
      case (stage_q)
        FETCH:     stage_d = DECODE;
        DECODE:    stage_d = EXECUTE;
        EXECUTE: begin
          stage_d   = MEMORY;
          exec_exit = 1'b1;
        end
        MEMORY:    stage_d = WRITEBACK;
        WRITEBACK: begin
          stage_d = FETCH;
          wb_exit = 1'b1;
        end
        default:   stage_d = FETCH;
      endcase
    end
  end

  assign taken_now = (zeroFlag & branchFlag) | unconditionalBranchFlag;

  pc_target_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_target (
    .pc     (pc_q),
    .offset (pcOffsetFilled),
    .taken  (taken_now),
    .target (target)
  );

  // Branch decision latched on EXECUTE exit; PC and retire count committed on WRITEBACK exit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      next_pc_q      <= RESET_PC;
      branch_taken_q <= 1'b0;
      retired_q      <= '0;
      pc_write_q     <= 1'b0;
    end else begin
      pc_write_q <= wb_exit;
      if (exec_exit) begin
        branch_taken_q <= taken_now;
        next_pc_q      <= target;
      end
      if (wb_exit) begin
        pc_q           <= next_pc_q;
        retired_q      <= retired_q + 32'd1;
        branch_taken_q <= 1'b0;
      end
    end
  end

  // One-hot stage enables, decoded from the stage register only.
  always_comb begin
    onehot = '0;
    case (stage_q)
      FETCH:     onehot[0] = 1'b1;
      DECODE:    onehot[1] = 1'b1;
      EXECUTE:   onehot[2] = 1'b1;
      MEMORY:    onehot[3] = 1'b1;
      WRITEBACK: onehot[4] = 1'b1;
      default:   onehot    = '0;
    endcase
  end

  assign fetchEnable     = onehot[0];
  assign decodeEnable    = onehot[1];
  assign executeEnable   = onehot[2];
  assign memoryEnable    = onehot[3];
  assign writebackEnable = onehot[4];

  assign stage        = stage_q;
  assign PC           = pc_q;
  assign pcWrite      = pc_write_q;
  assign branchTaken  = branch_taken_q;
  assign retiredCount = retired_q;

endmodule
